axil_rr_arb2: RTL and testbench

//  Round-robin 2:1 AXI-Lite arbiter sharing one AXI-Lite slave (axil_ram / register bank on the XDMA
//  m_axil path) between master 0 (XDMA BAR AXI-Lite) and master 1 (local config sequencer).

---
 rtl/axil_rr_arb2.sv | 219 +++++++++++++++++++++
 tb/tb_axil_rr_arb2.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_rr_arb2.sv
// axil_rr_arb2 -- round-robin 2:1 AXI-Lite arbiter
//
// Two AXI-Lite masters (s0_*, s1_*) share one AXI-Lite slave (m_*).
// The write and read paths are arbitrated independently, so a read
// and a write can be in flight at the same time. Each direction
// allows one outstanding transaction.
//
// Ports
//   clk, rst            common clock; asynchronous active-high reset
//   sN_axil_aw*/w*/b*   write channels of master N (N = 0, 1)
//   sN_axil_ar*/r*      read channels of master N
//   m_axil_*            the same channel set toward the shared slave
//
// A grant is registered on the edge that leaves IDLE, so forwarding
// starts one cycle after the request. Under contention the master
// that did not win the previous transaction in that direction wins.
// The ungranted master sees every ready/valid held at 0.
module axil_rr_arb2 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // master 0
  input  logic [ADDR_WIDTH-1:0] s0_axil_awaddr,
  input  logic [2:0]            s0_axil_awprot,
  input  logic                  s0_axil_awvalid,
  output logic                  s0_axil_awready,
  input  logic [DATA_WIDTH-1:0] s0_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s0_axil_wstrb,
  input  logic                  s0_axil_wvalid,
  output logic                  s0_axil_wready,
  output logic [1:0]            s0_axil_bresp,
  output logic                  s0_axil_bvalid,
  input  logic                  s0_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s0_axil_araddr,
  input  logic [2:0]            s0_axil_arprot,
  input  logic                  s0_axil_arvalid,
  output logic                  s0_axil_arready,
  output logic [DATA_WIDTH-1:0] s0_axil_rdata,
  output logic [1:0]            s0_axil_rresp,
  output logic                  s0_axil_rvalid,
  input  logic                  s0_axil_rready,
  // master 1
  input  logic [ADDR_WIDTH-1:0] s1_axil_awaddr,
  input  logic [2:0]            s1_axil_awprot,
  input  logic                  s1_axil_awvalid,
  output logic                  s1_axil_awready,
  input  logic [DATA_WIDTH-1:0] s1_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s1_axil_wstrb,
  input  logic                  s1_axil_wvalid,
  output logic                  s1_axil_wready,
  output logic [1:0]            s1_axil_bresp,
  output logic                  s1_axil_bvalid,
  input  logic                  s1_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s1_axil_araddr,
  input  logic [2:0]            s1_axil_arprot,
  input  logic                  s1_axil_arvalid,
  output logic                  s1_axil_arready,
  output logic [DATA_WIDTH-1:0] s1_axil_rdata,
  output logic [1:0]            s1_axil_rresp,
  output logic                  s1_axil_rvalid,
  input  logic                  s1_axil_rready,
  // shared slave
  output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
  output logic [2:0]            m_axil_awprot,
  output logic                  m_axil_awvalid,
  input  logic                  m_axil_awready,
  output logic [DATA_WIDTH-1:0] m_axil_wdata,
  output logic [STRB_WIDTH-1:0] m_axil_wstrb,
  output logic                  m_axil_wvalid,
  input  logic                  m_axil_wready,
  input  logic [1:0]            m_axil_bresp,
  input  logic                  m_axil_bvalid,
  output logic                  m_axil_bready,
  output logic [ADDR_WIDTH-1:0] m_axil_araddr,
  output logic [2:0]            m_axil_arprot,
  output logic                  m_axil_arvalid,
  input  logic                  m_axil_arready,
  input  logic [DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]            m_axil_rresp,
  input  logic                  m_axil_rvalid,
  output logic                  m_axil_rready
);

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_t;

  w_state_t r_wstate;
  r_state_t r_rstate;
  logic     r_wgnt, r_last_w, r_aw_done, r_w_done;
  logic     r_rgnt, r_last_r;

  // ---------------- write path ----------------
  logic w_aw_fwd, w_w_fwd, w_b_fwd, w_awready, w_wready, w_bvalid;
  logic w_aw_hs, w_w_hs, w_b_hs, w_wpick;

  assign w_aw_fwd = (r_wstate == W_ADDR) && !r_aw_done;
  assign w_w_fwd  = (r_wstate == W_ADDR) && !r_w_done;
  assign w_b_fwd  = (r_wstate == W_RESP);

  assign m_axil_awaddr  = r_wgnt ? s1_axil_awaddr : s0_axil_awaddr;
  assign m_axil_awprot  = r_wgnt ? s1_axil_awprot : s0_axil_awprot;
  assign m_axil_wdata   = r_wgnt ? s1_axil_wdata  : s0_axil_wdata;
  assign m_axil_wstrb   = r_wgnt ? s1_axil_wstrb  : s0_axil_wstrb;
  assign m_axil_awvalid = w_aw_fwd && (r_wgnt ? s1_axil_awvalid : s0_axil_awvalid);
  assign m_axil_wvalid  = w_w_fwd  && (r_wgnt ? s1_axil_wvalid  : s0_axil_wvalid);
  assign m_axil_bready  = w_b_fwd  && (r_wgnt ? s1_axil_bready  : s0_axil_bready);

  assign w_awready = w_aw_fwd && m_axil_awready;
  assign w_wready  = w_w_fwd  && m_axil_wready;
  assign w_bvalid  = w_b_fwd  && m_axil_bvalid;

  assign s0_axil_awready = w_awready && !r_wgnt;
  assign s1_axil_awready = w_awready &&  r_wgnt;
  assign s0_axil_wready  = w_wready  && !r_wgnt;
  assign s1_axil_wready  = w_wready  &&  r_wgnt;
  assign s0_axil_bvalid  = w_bvalid  && !r_wgnt;
  assign s1_axil_bvalid  = w_bvalid  &&  r_wgnt;
  assign s0_axil_bresp   = m_axil_bresp;
  assign s1_axil_bresp   = m_axil_bresp;

  assign w_aw_hs = m_axil_awvalid && m_axil_awready;
  assign w_w_hs  = m_axil_wvalid  && m_axil_wready;
  assign w_b_hs  = m_axil_bvalid  && m_axil_bready;
  // Lone requester wins; on contention the master not in r_last_w wins.
  assign w_wpick = (s0_axil_awvalid && s1_axil_awvalid) ? !r_last_w : s1_axil_awvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate  <= W_IDLE;
      r_wgnt    <= 1'b0;
      r_last_w  <= 1'b1;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (s0_axil_awvalid || s1_axil_awvalid) begin
            r_wgnt   <= w_wpick;
            r_wstate <= W_ADDR;
          end
        end
        W_ADDR: begin
          // AW and W complete independently; leave once both have.
          if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
            r_wstate  <= W_RESP;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            r_aw_done <= r_aw_done || w_aw_hs;
            r_w_done  <= r_w_done  || w_w_hs;
          end
        end
        W_RESP: begin
          if (w_b_hs) begin
            r_wstate <= W_IDLE;
            r_last_w <= r_wgnt;
          end
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // ---------------- read path ----------------
  logic w_ar_fwd, w_r_fwd, w_arready, w_rvalid, w_ar_hs, w_r_hs, w_rpick;

  assign w_ar_fwd = (r_rstate == R_ADDR);
  assign w_r_fwd  = (r_rstate == R_DATA);

  assign m_axil_araddr  = r_rgnt ? s1_axil_araddr : s0_axil_araddr;
  assign m_axil_arprot  = r_rgnt ? s1_axil_arprot : s0_axil_arprot;
  assign m_axil_arvalid = w_ar_fwd && (r_rgnt ? s1_axil_arvalid : s0_axil_arvalid);
  assign m_axil_rready  = w_r_fwd  && (r_rgnt ? s1_axil_rready  : s0_axil_rready);

  assign w_arready = w_ar_fwd && m_axil_arready;
  assign w_rvalid  = w_r_fwd  && m_axil_rvalid;

  assign s0_axil_arready = w_arready && !r_rgnt;
  assign s1_axil_arready = w_arready &&  r_rgnt;
  assign s0_axil_rvalid  = w_rvalid  && !r_rgnt;
  assign s1_axil_rvalid  = w_rvalid  &&  r_rgnt;
  assign s0_axil_rdata   = m_axil_rdata;
  assign s1_axil_rdata   = m_axil_rdata;
  assign s0_axil_rresp   = m_axil_rresp;
  assign s1_axil_rresp   = m_axil_rresp;

  assign w_ar_hs = m_axil_arvalid && m_axil_arready;
  assign w_r_hs  = m_axil_rvalid  && m_axil_rready;
  assign w_rpick = (s0_axil_arvalid && s1_axil_arvalid) ? !r_last_r : s1_axil_arvalid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rgnt   <= 1'b0;
      r_last_r <= 1'b1;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (s0_axil_arvalid || s1_axil_arvalid) begin
            r_rgnt   <= w_rpick;
            r_rstate <= R_ADDR;
          end
        end
        R_ADDR: if (w_ar_hs) r_rstate <= R_DATA;
        R_DATA: begin
          if (w_r_hs) begin
            r_rstate <= R_IDLE;
            r_last_r <= r_rgnt;
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_rr_arb2.sv
module tb_axil_rr_arb2;
  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // master-side drive (index = master number)
  logic [AW-1:0] awaddr [2];
  logic [2:0]    awprot [2];
  logic          awvalid[2];
  logic [DW-1:0] wdata  [2];
  logic [SW-1:0] wstrb  [2];
  logic          wvalid [2];
  logic          bready [2];
  logic [AW-1:0] araddr [2];
  logic [2:0]    arprot [2];
  logic          arvalid[2];
  logic          rready [2];

  logic s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid;
  logic s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid;
  logic [1:0] s0_bresp, s0_rresp, s1_bresp, s1_rresp;
  logic [DW-1:0] s0_rdata, s1_rdata;

  logic [AW-1:0] m_awaddr, m_araddr;
  logic [2:0]    m_awprot, m_arprot;
  logic          m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic          m_arvalid, m_arready, m_rvalid, m_rready;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [SW-1:0] m_wstrb;
  logic [1:0]    m_bresp, m_rresp;

  axil_rr_arb2 #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .s0_axil_awaddr(awaddr[0]), .s0_axil_awprot(awprot[0]), .s0_axil_awvalid(awvalid[0]),
    .s0_axil_awready(s0_awready), .s0_axil_wdata(wdata[0]), .s0_axil_wstrb(wstrb[0]),
    .s0_axil_wvalid(wvalid[0]), .s0_axil_wready(s0_wready), .s0_axil_bresp(s0_bresp),
    .s0_axil_bvalid(s0_bvalid), .s0_axil_bready(bready[0]), .s0_axil_araddr(araddr[0]),
    .s0_axil_arprot(arprot[0]), .s0_axil_arvalid(arvalid[0]), .s0_axil_arready(s0_arready),
    .s0_axil_rdata(s0_rdata), .s0_axil_rresp(s0_rresp), .s0_axil_rvalid(s0_rvalid),
    .s0_axil_rready(rready[0]),
    .s1_axil_awaddr(awaddr[1]), .s1_axil_awprot(awprot[1]), .s1_axil_awvalid(awvalid[1]),
    .s1_axil_awready(s1_awready), .s1_axil_wdata(wdata[1]), .s1_axil_wstrb(wstrb[1]),
    .s1_axil_wvalid(wvalid[1]), .s1_axil_wready(s1_wready), .s1_axil_bresp(s1_bresp),
    .s1_axil_bvalid(s1_bvalid), .s1_axil_bready(bready[1]), .s1_axil_araddr(araddr[1]),
    .s1_axil_arprot(arprot[1]), .s1_axil_arvalid(arvalid[1]), .s1_axil_arready(s1_arready),
    .s1_axil_rdata(s1_rdata), .s1_axil_rresp(s1_rresp), .s1_axil_rvalid(s1_rvalid),
    .s1_axil_rready(rready[1]),
    .m_axil_awaddr(m_awaddr), .m_axil_awprot(m_awprot), .m_axil_awvalid(m_awvalid),
    .m_axil_awready(m_awready), .m_axil_wdata(m_wdata), .m_axil_wstrb(m_wstrb),
    .m_axil_wvalid(m_wvalid), .m_axil_wready(m_wready), .m_axil_bresp(m_bresp),
    .m_axil_bvalid(m_bvalid), .m_axil_bready(m_bready), .m_axil_araddr(m_araddr),
    .m_axil_arprot(m_arprot), .m_axil_arvalid(m_arvalid), .m_axil_arready(m_arready),
    .m_axil_rdata(m_rdata), .m_axil_rresp(m_rresp), .m_axil_rvalid(m_rvalid),
    .m_axil_rready(m_rready)
  );

  // ---------------- AXI-Lite RAM slave with random ready stalls ----------------
  logic [31:0] smem [64] = '{default: '0};
  logic        s_aw_have, s_w_have, s_ar_have;
  logic [7:0]  s_awaddr, s_araddr;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  int unsigned wr_cnt = 0;
  logic [7:0]  aw_log[$];
  logic [7:0]  ar_log[$];

  wire aw_hs = m_awvalid & m_awready;
  wire w_hs  = m_wvalid & m_wready;
  wire ar_hs = m_arvalid & m_arready;
  wire r_hs  = m_rvalid & m_rready;
  wire do_wr = s_aw_have & s_w_have & ~m_bvalid;
  wire do_rd = s_ar_have & ~m_rvalid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_aw_have <= 1'b0; s_w_have <= 1'b0; s_ar_have <= 1'b0;
      m_awready <= 1'b0; m_wready <= 1'b0; m_arready <= 1'b0;
      m_bvalid  <= 1'b0; m_bresp  <= 2'b00;
      m_rvalid  <= 1'b0; m_rresp  <= 2'b00; m_rdata <= '0;
    end else begin
      if (aw_hs) begin s_awaddr <= m_awaddr; aw_log.push_back(m_awaddr); end
      if (w_hs)  begin s_wdata <= m_wdata; s_wstrb <= m_wstrb; end
      if (ar_hs) begin s_araddr <= m_araddr; ar_log.push_back(m_araddr); end
      s_aw_have <= aw_hs | (s_aw_have & ~do_wr);
      s_w_have  <= w_hs  | (s_w_have  & ~do_wr);
      s_ar_have <= ar_hs | (s_ar_have & ~do_rd);
      m_awready <= ~(aw_hs | (s_aw_have & ~do_wr)) & ($urandom_range(3) != 0);
      m_wready  <= ~(w_hs  | (s_w_have  & ~do_wr)) & ($urandom_range(3) != 0);
      m_arready <= ~(ar_hs | (s_ar_have & ~do_rd)) & ($urandom_range(3) != 0);
      if (do_wr) begin
        for (int i = 0; i < 4; i++)
          if (s_wstrb[i]) smem[s_awaddr[7:2]][8*i +: 8] <= s_wdata[8*i +: 8];
        wr_cnt   <= wr_cnt + 1;
        m_bvalid <= 1'b1;
        m_bresp  <= (s_awaddr >= 8'hF0) ? 2'b10 : 2'b00;
      end else if (m_bvalid & m_bready) begin
        m_bvalid <= 1'b0;
      end
      if (do_rd) begin
        m_rvalid <= 1'b1;
        m_rdata  <= smem[s_araddr[7:2]];
        m_rresp  <= (s_araddr >= 8'hF0) ? 2'b10 : 2'b00;
      end else if (r_hs) begin
        m_rvalid <= 1'b0;
      end
    end
  end

  int unsigned bhs_cnt [2] = '{0, 0};
  always @(posedge clk) begin
    if (s0_bvalid & bready[0]) bhs_cnt[0] <= bhs_cnt[0] + 1;
    if (s1_bvalid & bready[1]) bhs_cnt[1] <= bhs_cnt[1] + 1;
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [64] = '{default: '0};
  bit ref_last_w = 1'b1;
  bit ref_last_r = 1'b1;

  function automatic void ref_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++)
      if (s[i]) ref_mem[a[7:2]][8*i +: 8] = d[8*i +: 8];
  endfunction

  function automatic logic [1:0] ref_resp(input logic [7:0] a);
    return (a >= 8'hF0) ? 2'b10 : 2'b00;
  endfunction

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [14:0] all_hs();
    return {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready,
            s0_awready, s0_wready, s0_bvalid, s0_arready, s0_rvalid,
            s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid};
  endfunction

  // ---------------- master BFM tasks ----------------
  task automatic send_aw_w(input int m, input logic [7:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int wdly);
    awaddr[m] = a; awprot[m] = 3'(m + 1); wdata[m] = d; wstrb[m] = s;
    fork
      begin
        int n; bit got;
        n = 0; got = 0;
        awvalid[m] = 1'b1;
        while (!got && n < 300) begin
          @(posedge clk);
          got = (m == 0) ? s0_awready : s1_awready;
          n++;
        end
        #1 awvalid[m] = 1'b0;
        check("aw_handshake", 64'(got), 64'd1);
      end
      begin
        int n; bit got;
        n = 0; got = 0;
        repeat (wdly) @(negedge clk);
        wvalid[m] = 1'b1;
        while (!got && n < 300) begin
          @(posedge clk);
          got = (m == 0) ? s0_wready : s1_wready;
          n++;
        end
        #1 wvalid[m] = 1'b0;
        check("w_handshake", 64'(got), 64'd1);
      end
    join
  endtask

  task automatic wait_b(input int m, input int bhold, output logic [1:0] resp);
    int n; bit got;
    n = 0; got = 0; resp = 2'b11;
    repeat (bhold) @(negedge clk);
    bready[m] = 1'b1;
    while (!got && n < 300) begin
      @(posedge clk);
      got = (m == 0) ? s0_bvalid : s1_bvalid;
      if (got) resp = (m == 0) ? s0_bresp : s1_bresp;
      n++;
    end
    #1 bready[m] = 1'b0;
    check("b_handshake", 64'(got), 64'd1);
  endtask

  task automatic do_write(input int m, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int wdly, input int bhold);
    logic [1:0] resp;
    send_aw_w(m, a, d, s, wdly);
    wait_b(m, bhold, resp);
    check("bresp", 64'(resp), 64'(ref_resp(a)));
  endtask

  task automatic do_read(input int m, input logic [7:0] a, input int rhold,
                         output logic [31:0] data, output logic [1:0] resp);
    int n; bit got;
    n = 0; got = 0; data = 'x; resp = 2'b11;
    araddr[m] = a; arprot[m] = 3'(m + 4);
    arvalid[m] = 1'b1;
    while (!got && n < 300) begin
      @(posedge clk);
      got = (m == 0) ? s0_arready : s1_arready;
      n++;
    end
    #1 arvalid[m] = 1'b0;
    check("ar_handshake", 64'(got), 64'd1);
    repeat (rhold) @(negedge clk);
    rready[m] = 1'b1;
    got = 0; n = 0;
    while (!got && n < 300) begin
      @(posedge clk);
      got = (m == 0) ? s0_rvalid : s1_rvalid;
      if (got) begin
        data = (m == 0) ? s0_rdata : s1_rdata;
        resp = (m == 0) ? s0_rresp : s1_rresp;
      end
      n++;
    end
    #1 rready[m] = 1'b0;
    check("r_handshake", 64'(got), 64'd1);
  endtask

  // Single write by master m; the model updates memory and the pointer.
  task automatic single_write(input int m, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] s, input int wdly, input int bhold);
    aw_log.delete();
    do_write(m, a, d, s, wdly, bhold);
    ref_write(a, d, s);
    ref_last_w = m[0];
    check("single_aw_count", 64'(aw_log.size()), 64'd1);
    if (aw_log.size() > 0) check("single_aw_addr", 64'(aw_log[0]), 64'(a));
  endtask

  // Both masters raise awvalid in the same cycle; winner comes from the pointer.
  task automatic pair_write(input logic [7:0] a0, input logic [31:0] d0, input logic [3:0] st0,
                            input logic [7:0] a1, input logic [31:0] d1, input logic [3:0] st1);
    int first;
    first = ref_last_w ? 0 : 1;
    aw_log.delete();
    fork
      do_write(0, a0, d0, st0, $urandom_range(2), $urandom_range(2));
      do_write(1, a1, d1, st1, $urandom_range(2), $urandom_range(2));
    join
    check("pair_aw_count", 64'(aw_log.size()), 64'd2);
    if (aw_log.size() == 2) begin
      check("pair_first", 64'(aw_log[0]), 64'(first == 0 ? a0 : a1));
      check("pair_second", 64'(aw_log[1]), 64'(first == 0 ? a1 : a0));
    end
    ref_write(a0, d0, st0);
    ref_write(a1, d1, st1);
    ref_last_w = (first == 0);
  endtask

  task automatic read_check(input int m, input logic [7:0] a);
    logic [31:0] d; logic [1:0] r;
    do_read(m, a, $urandom_range(2), d, r);
    check("rdata", 64'(d), 64'(ref_mem[a[7:2]]));
    check("rresp", 64'(r), 64'(ref_resp(a)));
    ref_last_r = m[0];
  endtask

  task automatic pair_read(input logic [7:0] a0, input logic [7:0] a1);
    int first;
    logic [31:0] d0, d1; logic [1:0] r0, r1;
    first = ref_last_r ? 0 : 1;
    ar_log.delete();
    fork
      do_read(0, a0, $urandom_range(2), d0, r0);
      do_read(1, a1, $urandom_range(2), d1, r1);
    join
    check("pr_rdata0", 64'(d0), 64'(ref_mem[a0[7:2]]));
    check("pr_rdata1", 64'(d1), 64'(ref_mem[a1[7:2]]));
    check("pr_ar_count", 64'(ar_log.size()), 64'd2);
    if (ar_log.size() == 2) check("pr_first", 64'(ar_log[0]), 64'(first == 0 ? a0 : a1));
    ref_last_r = (first == 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int unsigned wc0, bc0;
    int n; bit got, viol;
    logic [31:0] rd; logic [1:0] rr;
    for (int i = 0; i < 2; i++) begin
      awaddr[i] = '0; awprot[i] = '0; awvalid[i] = 0; wdata[i] = '0; wstrb[i] = '0;
      wvalid[i] = 0; bready[i] = 0; araddr[i] = '0; arprot[i] = '0; arvalid[i] = 0; rready[i] = 0;
    end
    #1 check("reset_outputs", 64'(all_hs()), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", 64'(all_hs()), 64'd0);

    // contention from reset: master 0 wins first
    @(negedge clk);
    pair_write(8'h04, 32'h11111111, 4'hF, 8'h08, 32'h22222222, 4'hF);

    // single s0 write; address reaches the slave one cycle after request
    @(negedge clk);
    fork
      single_write(0, 8'h10, 32'hDEADBEEF, 4'hF, 0, 0);
      begin
        @(negedge clk);
        check("t1_m_awvalid", 64'(m_awvalid), 64'd1);
        check("t1_m_awaddr", 64'(m_awaddr), 64'h10);
        check("t1_m_awprot", 64'(m_awprot), 64'd1);
        check("t1_s1_quiet", 64'({s1_awready, s1_wready, s1_bvalid, s1_arready, s1_rvalid}), 64'd0);
      end
    join

    // master 0 won last, so master 1 wins this contention
    @(negedge clk);
    pair_write(8'h0C, 32'h33333333, 4'hF, 8'h14, 32'h44444444, 4'hF);
    @(negedge clk); read_check(0, 8'h04);
    @(negedge clk); read_check(1, 8'h08);
    @(negedge clk); read_check(0, 8'h10);

    // s1: W arrives 3 cycles after AW; exactly one slave write and one B
    @(negedge clk);
    wc0 = wr_cnt; bc0 = bhs_cnt[1];
    single_write(1, 8'h30, 32'hA5A5_0F0F, 4'b0110, 3, 0);
    repeat (3) @(negedge clk);
    check("t3_slave_writes", 64'(wr_cnt - wc0), 64'd1);
    check("t3_s1_b_count", 64'(bhs_cnt[1] - bc0), 64'd1);

    // concurrent write (s0) and read (s1)
    @(negedge clk);
    fork
      single_write(0, 8'h20, 32'hCAFEF00D, 4'hF, 0, 1);
      read_check(1, 8'h04);
      begin
        @(negedge clk);
        check("t4_concurrent", 64'({m_awvalid, m_arvalid}), 64'b11);
      end
    join

    // s0 stalls bready; pending s1 must not be granted until the B handshake
    @(negedge clk);
    bc0 = bhs_cnt[0]; viol = 0;
    aw_log.delete();
    fork
      do_write(0, 8'h24, 32'h5555AAAA, 4'hF, 0, 8);
      begin
        repeat (2) @(negedge clk);
        do_write(1, 8'h28, 32'h6666BBBB, 4'hF, 0, 0);
      end
      begin
        n = 0;
        while (bhs_cnt[0] == bc0 && n < 300) begin
          @(negedge clk);
          if (bhs_cnt[0] == bc0 && s1_awready) viol = 1;
          n++;
        end
      end
    join
    check("t5_s1_blocked", 64'(viol), 64'd0);
    check("t5_order", 64'({aw_log.size() == 2 ? aw_log[0] : 8'hxx, aw_log.size() == 2 ? aw_log[1] : 8'hxx}), 64'h2428);
    ref_write(8'h24, 32'h5555AAAA, 4'hF);
    ref_write(8'h28, 32'h6666BBBB, 4'hF);
    ref_last_w = 1'b1;

    // error response path
    @(negedge clk); single_write(0, 8'hF4, 32'h01020304, 4'hF, 0, 0);
    @(negedge clk); read_check(1, 8'hF4);

    // randomized traffic
    for (int it = 0; it < 14; it++) begin
      logic [7:0] a;
      a = {2'b01, 4'($urandom_range(15)), 2'b00};
      @(negedge clk);
      case ($urandom_range(3))
        0: single_write($urandom_range(1), a, $urandom, 4'($urandom), $urandom_range(3), $urandom_range(2));
        1: pair_write(a, $urandom, 4'($urandom), a ^ 8'h04, $urandom, 4'($urandom));
        2: pair_read(a, a ^ 8'h08);
        default: read_check($urandom_range(1), a);
      endcase
    end

    // reset asserted while s0 sits in the response phase
    @(negedge clk);
    send_aw_w(0, 8'h38, 32'h77778888, 4'hF, 0);
    ref_write(8'h38, 32'h77778888, 4'hF);
    n = 0; got = 0;
    while (!got && n < 50) begin
      @(negedge clk);
      got = s0_bvalid;
      n++;
    end
    check("t6_in_resp", 64'(got), 64'd1);
    #2 rst = 1'b1;
    #1 check("t6_reset_outputs", 64'(all_hs()), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ref_last_w = 1'b1; ref_last_r = 1'b1;
    @(negedge clk);
    pair_write(8'h2C, 32'h9999CCCC, 4'hF, 8'h34, 32'hABCD1234, 4'hF);
    @(negedge clk);
    pair_read(8'h38, 8'h2C);
    @(negedge clk);
    do_read(1, 8'h34, 0, rd, rr);
    check("t6_readback", 64'(rd), 64'(ref_mem[8'h34 >> 2]));

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
